axi_read_arb_rr: RTL and testbench
==================================

AXI_READ_ARB_RR -- requirements
Module: axi_read_arb_rr

Interface
REQ-001 Parameters SHALL be: AXI_ADDR_BITWIDTH, default 29, address and length width; AXI_DATA_BITWIDTH, default 128, data width; ARB_NUM, default 4, requester count (1..16); OT_DEPTH, default 4, maximum outstanding commands (power of 2, 2..16).
REQ-002 Clock and reset SHALL be one clock with asynchronous, active-low reset, named sys_clk and sys_rst_n.
REQ-003 sys_clk  in  1  sole clock; all logic on the rising edge.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 read_cmd_valid  in  ARB_NUM  per-requester command request.
REQ-006 read_cmd_ready  out  ARB_NUM  per-requester command accept, one-hot or zero.
REQ-007 read_cmd_addr  in  ARB_NUM*AXI_ADDR_BITWIDTH  packed per-requester base address.
REQ-008 read_cmd_len  in  ARB_NUM*AXI_ADDR_BITWIDTH  packed per-requester size.
REQ-009 read_axis_valid / read_axis_last  out  ARB_NUM  per-requester data stream.
REQ-010 read_axis_ready  in  ARB_NUM  per-requester data backpressure.
REQ-011 read_axis_data  out  ARB_NUM*AXI_DATA_BITWIDTH  arb_read_axis_data broadcast to every lane.
REQ-012 arb_read_cmd_valid / arb_read_cmd_ready  out / in  1 / 1  downstream command handshake.
REQ-013 arb_read_cmd_addr / arb_read_cmd_len  out  AXI_ADDR_BITWIDTH each  granted command fields.
REQ-014 arb_read_axis_valid / arb_read_axis_data / arb_read_axis_last  in  1 / AXI_DATA_BITWIDTH / 1  downstream data.
REQ-015 arb_read_axis_ready  out  1  downstream data backpressure.
REQ-016 rd_outstanding  out  $clog2(OT_DEPTH+1)  commands granted whose last beat has not completed.

Function
REQ-017 The command slot SHALL be free when arb_read_cmd_valid is 0 and the order FIFO is not full, as sampled at the start of the cycle.
REQ-018 With the slot free and any read_cmd_valid set, the block SHALL combinationally assert read_cmd_ready for exactly one winner in the same cycle.
REQ-019 Round-robin arbitration SHALL search from (last_grant+1) mod ARB_NUM upward with wrap-around, then update last_grant to the winner.
REQ-020 On a grant in cycle N, the block SHALL register the winner's addr and len, assert arb_read_cmd_valid in N+1, and push the winner ID into the order FIFO.
REQ-021 arb_read_cmd_valid, addr and len SHALL hold stable until arb_read_cmd_ready; the slot frees in the cycle after the handshake, giving at most one grant per two cycles.
REQ-022 While the order FIFO is empty, the block SHALL drive arb_read_axis_ready=0 and all read_axis_valid/last=0.
REQ-023 While the FIFO is non-empty with head H, the block SHALL drive read_axis_valid[H]=arb_read_axis_valid, read_axis_last[H]=arb_read_axis_last and arb_read_axis_ready=read_axis_ready[H], and 0 on all other lanes.
REQ-024 A beat with valid&ready&last SHALL pop the head; the next head routes from the following cycle.
REQ-025 Simultaneous push and pop SHALL both take effect, leaving the count unchanged; a push while full cannot occur (REQ-017).
REQ-026 rd_outstanding SHALL equal the FIFO count (+1 push, -1 pop, net 0 when both occur).
REQ-027 The block SHALL pass len through unmodified; data routing SHALL depend only on last.
REQ-028 ARB_NUM=1 SHALL degenerate to a pass-through with the same handshakes.

Reset
REQ-029 Reset SHALL drive: read_cmd_ready=0, arb_read_cmd_valid=0, addr/len=0, FIFO empty, rd_outstanding=0, last_grant=ARB_NUM-1 (channel 0 wins first), and every read_axis_valid/last and arb_read_axis_ready=0.
REQ-030 Reset asserted mid-transfer SHALL discard all outstanding IDs immediately; any in-flight downstream data is not routed.

Configuration
REQ-031 Macro AXI_RD_ARB_FIXED_PRIO_EN: when defined, the lowest-index valid requester SHALL always win and last_grant is unused; when undefined, round-robin per REQ-019 applies.

Structure
REQ-032 A shared package axi_arb_pkg SHALL hold the ID width function (clog2 of ARB_NUM, minimum 1) and the run_num invalid encoding constant.
REQ-033 The order FIFO SHALL be the sub-module axi_rd_arb_order_fifo (register array, OT_DEPTH x ID width, push/pop/full/empty/count).

Verification
REQ-034 Reset, then read_cmd_valid=4'b1111 held -> grants in order 0,1,2,3,0 on alternating cycles, each addr/len matching its requester.
REQ-035 arb_read_cmd_ready tied 1 and data never sent -> exactly 4 grants, then read_cmd_ready stays 0 and rd_outstanding=4.
REQ-036 Grants to 2 then 0, then two 3-beat bursts -> burst 1 on lane 2 only, burst 2 on lane 0 only, rd_outstanding 2->1->0.
REQ-037 read_axis_ready[H]=0 for 5 cycles mid-burst -> arb_read_axis_ready=0 for those cycles, no beat lost or duplicated.
REQ-038 Final last beat popped in the same cycle as a new grant -> rd_outstanding unchanged, and the new ID heads the FIFO next cycle.
REQ-039 With AXI_RD_ARB_FIXED_PRIO_EN, requests 4'b1010 held -> channel 1 wins every grant and channel 3 is starved.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared ID-width helper and "no winner" encoding for the read arbiter
package axi_arb_pkg;

  localparam int RUN_NUM_BITS = 5;
  localparam logic [RUN_NUM_BITS-1:0] RUN_NUM_INVALID = '1;

  // One bit minimum so a single-requester build still has a storable ID
  function automatic int arb_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_rd_arb_order_fifo.sv
// rtl/axi_rd_arb_order_fifo.sv - in-order queue of granted requester IDs awaiting read data
module axi_rd_arb_order_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_id,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_id,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_id = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_id;
  end

  // Pointers wrap on their own because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_read_arb_rr.sv
// rtl/axi_read_arb_rr.sv - N-to-1 AXI read command arbiter with in-order data return routing
// Define AXI_RD_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module axi_read_arb_rr
  import axi_arb_pkg::*;
#(
  parameter int AXI_ADDR_BITWIDTH = 29,
  parameter int AXI_DATA_BITWIDTH = 128,
  parameter int ARB_NUM           = 4,
  parameter int OT_DEPTH          = 4
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst_n,
  input  logic [ARB_NUM-1:0]                     read_cmd_valid,
  output logic [ARB_NUM-1:0]                     read_cmd_ready,
  input  logic [ARB_NUM*AXI_ADDR_BITWIDTH-1:0]   read_cmd_addr,
  input  logic [ARB_NUM*AXI_ADDR_BITWIDTH-1:0]   read_cmd_len,
  output logic [ARB_NUM-1:0]                     read_axis_valid,
  output logic [ARB_NUM-1:0]                     read_axis_last,
  input  logic [ARB_NUM-1:0]                     read_axis_ready,
  output logic [ARB_NUM*AXI_DATA_BITWIDTH-1:0]   read_axis_data,
  output logic                                   arb_read_cmd_valid,
  input  logic                                   arb_read_cmd_ready,
  output logic [AXI_ADDR_BITWIDTH-1:0]           arb_read_cmd_addr,
  output logic [AXI_ADDR_BITWIDTH-1:0]           arb_read_cmd_len,
  input  logic                                   arb_read_axis_valid,
  input  logic [AXI_DATA_BITWIDTH-1:0]           arb_read_axis_data,
  input  logic                                   arb_read_axis_last,
  output logic                                   arb_read_axis_ready,
  output logic [$clog2(OT_DEPTH+1)-1:0]          rd_outstanding
);

  localparam int ID_W = arb_id_width(ARB_NUM);
  localparam int AW   = AXI_ADDR_BITWIDTH;

  logic                    r_cmd_valid;
  logic [AW-1:0]           r_cmd_addr;
  logic [AW-1:0]           r_cmd_len;
  logic [RUN_NUM_BITS-1:0] w_winner;
  logic [ID_W-1:0]         w_win_id;
  logic                    w_slot_free;
  logic                    w_grant;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [ID_W-1:0]         w_head_id;
  logic                    w_pop;

`ifndef AXI_RD_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]         r_last_grant;
  int                      w_scan_idx;
`endif

  always_comb begin
    w_winner = RUN_NUM_INVALID;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    for (int i = ARB_NUM - 1; i >= 0; i--) begin
      if (read_cmd_valid[i]) w_winner = RUN_NUM_BITS'(i);
    end
`else
    w_scan_idx = 0;
    for (int i = 0; i < ARB_NUM; i++) begin
      w_scan_idx = (int'(r_last_grant) + 1 + i) % ARB_NUM;
      if (w_winner == RUN_NUM_INVALID && read_cmd_valid[w_scan_idx])
        w_winner = RUN_NUM_BITS'(w_scan_idx);
    end
`endif
  end

  // Reset gates the accept so no requester sees ready while the block is held in reset
  assign w_slot_free = sys_rst_n && !r_cmd_valid && !w_fifo_full;
  assign w_grant     = w_slot_free && (w_winner != RUN_NUM_INVALID);
  assign w_win_id    = w_winner[ID_W-1:0];

  always_comb begin
    read_cmd_ready = '0;
    if (w_grant) read_cmd_ready[w_win_id] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_len   <= '0;
    end else if (w_grant) begin
      r_cmd_valid <= 1'b1;
      r_cmd_addr  <= read_cmd_addr[w_win_id*AW +: AW];
      r_cmd_len   <= read_cmd_len[w_win_id*AW +: AW];
    end else if (r_cmd_valid && arb_read_cmd_ready) begin
      r_cmd_valid <= 1'b0;
    end
  end

`ifndef AXI_RD_ARB_FIXED_PRIO_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   r_last_grant <= ID_W'(ARB_NUM - 1);
    else if (w_grant) r_last_grant <= w_win_id;
  end
`endif

  assign arb_read_cmd_valid = r_cmd_valid;
  assign arb_read_cmd_addr  = r_cmd_addr;
  assign arb_read_cmd_len   = r_cmd_len;

  axi_rd_arb_order_fifo #(
    .DEPTH (OT_DEPTH),
    .WIDTH (ID_W)
  ) u_order_fifo (
    .i_clk     (sys_clk),
    .i_rst_n   (sys_rst_n),
    .i_push    (w_grant),
    .i_push_id (w_win_id),
    .i_pop     (w_pop),
    .o_head_id (w_head_id),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (rd_outstanding)
  );

  // Only the head requester's lane sees the downstream stream; the data bus is shared
  always_comb begin
    read_axis_valid     = '0;
    read_axis_last      = '0;
    arb_read_axis_ready = 1'b0;
    if (!w_fifo_empty) begin
      for (int i = 0; i < ARB_NUM; i++) begin
        if (w_head_id == ID_W'(i)) begin
          read_axis_valid[i]  = arb_read_axis_valid;
          read_axis_last[i]   = arb_read_axis_last;
          arb_read_axis_ready = read_axis_ready[i];
        end
      end
    end
  end

  assign read_axis_data = {ARB_NUM{arb_read_axis_data}};
  assign w_pop          = arb_read_axis_valid && arb_read_axis_ready && arb_read_axis_last;

endmodule

// File: tb/tb_axi_read_arb_rr.sv
// tb/tb_axi_read_arb_rr.sv - directed and randomized bench for axi_read_arb_rr against a queue-based model
module tb_axi_read_arb_rr;

  localparam int AW  = 29;
  localparam int DW  = 128;
  localparam int N   = 4;
  localparam int OT  = 4;
  localparam int OTW = $clog2(OT + 1);

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [N-1:0]      read_cmd_valid;
  logic [N-1:0]      read_cmd_ready;
  logic [N*AW-1:0]   read_cmd_addr;
  logic [N*AW-1:0]   read_cmd_len;
  logic [N-1:0]      read_axis_valid;
  logic [N-1:0]      read_axis_last;
  logic [N-1:0]      read_axis_ready;
  logic [N*DW-1:0]   read_axis_data;
  logic              arb_read_cmd_valid;
  logic              arb_read_cmd_ready;
  logic [AW-1:0]     arb_read_cmd_addr;
  logic [AW-1:0]     arb_read_cmd_len;
  logic              arb_read_axis_valid;
  logic [DW-1:0]     arb_read_axis_data;
  logic              arb_read_axis_last;
  logic              arb_read_axis_ready;
  logic [OTW-1:0]    rd_outstanding;

  axi_read_arb_rr #(
    .AXI_ADDR_BITWIDTH (AW),
    .AXI_DATA_BITWIDTH (DW),
    .ARB_NUM           (N),
    .OT_DEPTH          (OT)
  ) dut (
    .sys_clk             (sys_clk),
    .sys_rst_n           (sys_rst_n),
    .read_cmd_valid      (read_cmd_valid),
    .read_cmd_ready      (read_cmd_ready),
    .read_cmd_addr       (read_cmd_addr),
    .read_cmd_len        (read_cmd_len),
    .read_axis_valid     (read_axis_valid),
    .read_axis_last      (read_axis_last),
    .read_axis_ready     (read_axis_ready),
    .read_axis_data      (read_axis_data),
    .arb_read_cmd_valid  (arb_read_cmd_valid),
    .arb_read_cmd_ready  (arb_read_cmd_ready),
    .arb_read_cmd_addr   (arb_read_cmd_addr),
    .arb_read_cmd_len    (arb_read_cmd_len),
    .arb_read_axis_valid (arb_read_axis_valid),
    .arb_read_axis_data  (arb_read_axis_data),
    .arb_read_axis_last  (arb_read_axis_last),
    .arb_read_axis_ready (arb_read_axis_ready),
    .rd_outstanding      (rd_outstanding)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pending command slot, last winner, queue of IDs awaiting data
  bit            m_cmd_v;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_len;
  int            m_last;
  int            m_q[$];
  int            grants[$];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_cmd_v = 0;
    m_addr  = '0;
    m_len   = '0;
    m_last  = N - 1;
    m_q.delete();
  endtask

  // Check all outputs mid-cycle, advance the model, return just after the next rising edge
  task automatic step();
    int           w;
    int           h;
    logic [N-1:0] e_rdy, e_v, e_l;
    logic         e_ar;
    @(negedge sys_clk);
    if (!sys_rst_n) begin
      model_reset();
      chk("rst_cmd_ready", read_cmd_ready, '0);
      chk("rst_arb_valid", arb_read_cmd_valid, 0);
      chk("rst_addr", arb_read_cmd_addr, 0);
      chk("rst_len", arb_read_cmd_len, 0);
      chk("rst_outstanding", rd_outstanding, 0);
      chk("rst_axis_valid", read_axis_valid, 0);
      chk("rst_axis_last", read_axis_last, 0);
      chk("rst_axis_ready", arb_read_axis_ready, 0);
    end else begin
      w = -1;
      if (!m_cmd_v && m_q.size() < OT) w = pick(read_cmd_valid, m_last);
      e_rdy = '0;
      if (w >= 0) e_rdy[w] = 1'b1;
      e_v = '0; e_l = '0; e_ar = 1'b0;
      if (m_q.size() > 0) begin
        h = m_q[0];
        e_v[h] = arb_read_axis_valid;
        e_l[h] = arb_read_axis_last;
        e_ar   = read_axis_ready[h];
      end
      chk("cmd_ready", read_cmd_ready, e_rdy);
      chk("arb_cmd_valid", arb_read_cmd_valid, m_cmd_v);
      chk("arb_cmd_addr", arb_read_cmd_addr, m_addr);
      chk("arb_cmd_len", arb_read_cmd_len, m_len);
      chk("outstanding", rd_outstanding, m_q.size());
      chk("axis_valid", read_axis_valid, e_v);
      chk("axis_last", read_axis_last, e_l);
      chk("arb_axis_ready", arb_read_axis_ready, e_ar);
      chk("axis_data", read_axis_data, {N{arb_read_axis_data}});
      if (m_cmd_v && arb_read_cmd_ready) m_cmd_v = 0;
      if (m_q.size() > 0 && arb_read_axis_valid && read_axis_ready[m_q[0]] && arb_read_axis_last)
        void'(m_q.pop_front());
      if (w >= 0) begin
        m_cmd_v = 1;
        m_addr  = read_cmd_addr[w*AW +: AW];
        m_len   = read_cmd_len[w*AW +: AW];
        m_last  = w;
        m_q.push_back(w);
        grants.push_back(w);
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
  endtask

  task automatic set_data(input logic v, input logic l);
    arb_read_axis_valid = v;
    arb_read_axis_last  = l;
    arb_read_axis_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    sys_rst_n           = 1'b0;
    read_cmd_valid      = '0;
    read_axis_ready     = '0;
    arb_read_cmd_ready  = 1'b0;
    arb_read_axis_valid = 1'b0;
    arb_read_axis_last  = 1'b0;
    arb_read_axis_data  = '0;
    for (int i = 0; i < N; i++) begin
      read_cmd_addr[i*AW +: AW] = AW'(32'h100 + i);
      read_cmd_len[i*AW +: AW]  = AW'(i + 1);
    end
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    do_reset();

    // All requesters held with data never returned: four grants, then the order queue is full
    grants.delete();
    read_cmd_valid     = '1;
    arb_read_cmd_ready = 1'b1;
    repeat (12) step();
    chk("full_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      chk("full_grant_order", grants[i], 0);
`else
      chk("full_grant_order", grants[i], i);
`endif
    end
    chk("full_outstanding", rd_outstanding, 4);
    chk("full_no_ready", read_cmd_ready, 0);

    read_cmd_valid  = '0;
    read_axis_ready = '1;
    set_data(1, 1);
    repeat (4) step();
    chk("drain_outstanding", rd_outstanding, 0);
    set_data(0, 0);
    read_cmd_valid = '1;
    step();
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    chk("fifth_grant", grants[$], 0);
`else
    chk("fifth_grant", grants[$], 0);
    chk("fifth_grant_cnt", grants.size(), 5);
`endif
    read_cmd_valid = '0;
    step();

    // Grant lane 2 then lane 0, then return one 3-beat burst for each
    do_reset();
    read_cmd_valid = 4'b0100; step();
    read_cmd_valid = '0;      step();
    read_cmd_valid = 4'b0001; step();
    read_cmd_valid = '0;      step();
    chk("two_outstanding", rd_outstanding, 2);
    for (int b = 0; b < 2; b++) begin
      for (int beat = 0; beat < 3; beat++) begin
        set_data(1, beat == 2);
        #1;
        chk("burst_lane", read_axis_valid, (b == 0) ? 4'b0100 : 4'b0001);
        step();
      end
      chk("burst_outstanding", rd_outstanding, 1 - b);
    end
    set_data(0, 0);
    step();

    // Lane stall mid-burst holds the downstream ready low
    read_cmd_valid = 4'b1000; step();
    read_cmd_valid = '0;      step();
    set_data(1, 0); step();
    read_axis_ready = 4'b0111;
    for (int c = 0; c < 5; c++) begin
      set_data(1, 0);
      #1;
      chk("stall_ready", arb_read_axis_ready, 0);
      step();
    end
    read_axis_ready = '1;
    set_data(1, 1); step();
    chk("stall_done", rd_outstanding, 0);

    // Last beat pops in the same cycle a new command is granted
    read_cmd_valid = 4'b0001; set_data(0, 0); step();
    read_cmd_valid = '0; step();
    read_cmd_valid = 4'b0010; set_data(1, 1); step();
    read_cmd_valid = '0; set_data(1, 0);
    #1;
    chk("swap_outstanding", rd_outstanding, 1);
    chk("swap_new_head", read_axis_valid, 4'b0010);
    step();
    set_data(1, 1); step();
    set_data(0, 0); step();

    // Randomized traffic with one asynchronous reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      read_cmd_valid     = N'($urandom);
      arb_read_cmd_ready = ($urandom_range(0, 9) < 7);
      read_axis_ready    = N'($urandom) | N'($urandom);
      set_data($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        read_cmd_addr[i*AW +: AW] = AW'($urandom);
        read_cmd_len[i*AW +: AW]  = AW'($urandom);
      end
      if (cyc == 1500) begin
        #2;
        do_reset();
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
